// File: rtl/bloom_filter.sv
// ---------------------------------------------------------------------------
// bloom_filter
//
// Single-hash Bloom filter membership lookup, one filter of a weightless
// neural-network discriminator. A pre-hashed index addresses a ROM whose
// contents come from the DATA parameter. The stored bit comes out on the
// following clock.
//
// Parameters
//   INPUT_WIDTH  width of hashed_inp; the filter holds 2**INPUT_WIDTH bits
//   DATA         unpacked bit array [0:2**INPUT_WIDTH-1], entry i = DATA[i]
//
// Ports
//   clk         in   1            single clock, rising edge
//   rst         in   1            asynchronous, active-low reset
//   inp_vld     in   1            hashed_inp carries a lookup this cycle
//   hashed_inp  in   INPUT_WIDTH  filter index to look up
//   outp_vld    out  1            result carries a lookup result this cycle
//   result      out  1            DATA[index] of the lookup accepted last cycle
//
// Handshake: valid-only and fully pipelined. A lookup is accepted on every
// rising edge where inp_vld=1. There is no ready and no backpressure.
// outp_vld is inp_vld delayed by one clock. result changes only when a lookup
// is accepted and otherwise holds its last value, so consumers qualify it with
// outp_vld. hashed_inp is ignored while inp_vld=0.
// ---------------------------------------------------------------------------
module bloom_filter #(
  parameter int INPUT_WIDTH = 8,
  parameter bit DATA [0:2**INPUT_WIDTH-1] = '{default: 1'b0}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inp_vld,
  input  logic [INPUT_WIDTH-1:0] hashed_inp,
  output logic                   outp_vld,
  output logic                   result
);

  // Combinational ROM read. Every index value is a legal entry.
  logic rom_bit;

  assign rom_bit = DATA[hashed_inp];

  // An asserted reset discards any in-flight lookup right away.
  // Releasing reset needs no extra cycle: the next edge is a normal edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outp_vld <= 1'b0;
      result   <= 1'b0;
    end else begin
      outp_vld <= inp_vld;
      if (inp_vld) begin
        result <= rom_bit;
      end
    end
  end

endmodule

// File: tb/tb_bloom_filter.sv
// ---------------------------------------------------------------------------
// tb_bloom_filter
//
// Testbench for bloom_filter. The filter holds a fixed 60-entry head pattern
// followed by pseudo-random fill. The reference model works out each entry
// from those two constants. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge that follows.
// ---------------------------------------------------------------------------
module tb_bloom_filter;

  localparam int W = 8;
  localparam int N = 256;

  // Entries 0..59, entry 0 written first (entry i is bit 59-i).
  localparam bit [59:0] HEAD =
    60'b0101100000_0110111000_1111111011_1001011000_1111111010_0111001011;
  // Entries 60..255 come from this constant (entry i is bit i).
  localparam bit [255:0] FILL =
    256'h9e37_79b9_7f4a_7c15_f39c_c060_5ced_c834_1082_276b_f3a2_7251_f86c_6a11_d0c1_8e95;

  typedef bit rom_t [0:N-1];

  // Reference model: the filter bit for an index.
  function automatic bit ref_bit(input int idx);
    if (idx < 60) return HEAD[59-idx];
    return FILL[idx];
  endfunction

  function automatic rom_t build_rom();
    rom_t r;
    for (int i = 0; i < N; i++) r[i] = ref_bit(i);
    return r;
  endfunction

  localparam rom_t DATA_TB = build_rom();

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         inp_vld;
  logic [W-1:0] hashed_inp;
  logic         outp_vld;
  logic         result;

  always #5 clk = ~clk;

  bloom_filter #(
    .INPUT_WIDTH(W),
    .DATA       (DATA_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inp_vld   (inp_vld),
    .hashed_inp(hashed_inp),
    .outp_vld  (outp_vld),
    .result    (result)
  );

  // ---------------- scoreboard state ----------------
  int   tests_run = 0;
  int   failed    = 0;
  logic exp_res   = 1'b0;     // model of the held result bit
  logic [1:0] exp_q[$];       // {expected outp_vld, expected result}

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      inp_vld    = ~inp_vld;
      hashed_inp = 8'd42;
      @(posedge clk);
      #1;
      tests_run++;
      if (outp_vld !== 1'b0 || result !== 1'b0) begin
        failed++;
        $display("FAIL reset_hold[%0d]: outp_vld=%b result=%b, expected 0 0", i, outp_vld, result);
      end
    end
    // Release reset, load a 1, then assert reset between edges.
    @(negedge clk);
    rst        = 1'b1;
    inp_vld    = 1'b1;
    hashed_inp = 8'd42;
    @(negedge clk);
    inp_vld = 1'b0;
    tests_run++;
    if (outp_vld !== 1'b1 || result !== 1'b1) begin
      failed++;
      $display("FAIL reset_preload: outp_vld=%b result=%b, expected 1 1", outp_vld, result);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (outp_vld !== 1'b0 || result !== 1'b0) begin
      failed++;
      $display("FAIL reset_async: outp_vld=%b result=%b, expected 0 0", outp_vld, result);
    end
    @(negedge clk);
    rst     = 1'b1;
    exp_res = 1'b0;
  endtask

  task automatic test_single();
    inp_vld    = 1'b1;
    hashed_inp = 8'd42;
    @(negedge clk);
    inp_vld    = 1'b0;
    hashed_inp = W'($urandom_range(0, N-1));
    tests_run++;
    if (outp_vld !== 1'b1 || result !== 1'b1) begin
      failed++;
      $display("FAIL single_hit: outp_vld=%b result=%b, expected 1 1", outp_vld, result);
    end
    @(negedge clk);
    tests_run++;
    if (outp_vld !== 1'b0 || result !== 1'b1) begin
      failed++;
      $display("FAIL single_hold: outp_vld=%b result=%b, expected 0 1", outp_vld, result);
    end
    exp_res = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] idx [4];
    logic         exp [4];
    idx = '{8'd52, 8'd50, 8'd1, 8'd0};
    exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    inp_vld    = 1'b1;
    hashed_inp = idx[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) hashed_inp = idx[i+1];
      else       inp_vld    = 1'b0;
      tests_run++;
      if (outp_vld !== 1'b1 || result !== exp[i]) begin
        failed++;
        $display("FAIL b2b[%0d] idx=%0d: outp_vld=%b result=%b, expected 1 %b",
                 i, idx[i], outp_vld, result, exp[i]);
      end
    end
    exp_res = 1'b0;
  endtask

  task automatic test_idle_gap();
    inp_vld    = 1'b0;
    hashed_inp = 8'd42;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (outp_vld !== 1'b0 || result !== exp_res) begin
        failed++;
        $display("FAIL idle_gap[%0d]: outp_vld=%b result=%b, expected 0 %b",
                 i, outp_vld, result, exp_res);
      end
    end
  endtask

  // 96 back-to-back valid lookups, then 64 cycles with random inp_vld.
  task automatic test_random();
    logic [1:0] e;
    logic       v;
    for (int c = 0; c <= 160; c++) begin
      @(negedge clk);
      if (c > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (outp_vld !== e[1] || result !== e[0]) begin
          failed++;
          $display("FAIL random[%0d]: outp_vld=%b result=%b, expected %b %b",
                   c-1, outp_vld, result, e[1], e[0]);
        end
      end
      if (c < 160) begin
        v          = (c < 96) ? 1'b1 : 1'($urandom_range(0, 1));
        inp_vld    = v;
        hashed_inp = W'($urandom_range(0, N-1));
        if (v) exp_res = ref_bit(int'(hashed_inp));
        exp_q.push_back({v, exp_res});
      end else begin
        inp_vld = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] idx;
    inp_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hashed_inp = W'($urandom_range(0, N-1));
      @(negedge clk);
    end
    // A lookup is in flight on the next edge; reset lands right after it.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if (outp_vld !== 1'b0 || result !== 1'b0) begin
      failed++;
      $display("FAIL midstream_async: outp_vld=%b result=%b, expected 0 0", outp_vld, result);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (outp_vld !== 1'b0 || result !== 1'b0) begin
      failed++;
      $display("FAIL midstream_hold: outp_vld=%b result=%b, expected 0 0", outp_vld, result);
    end
    @(negedge clk);
    rst = 1'b1;
    // Choose an index whose bit is 1 so the first result differs from the reset value.
    idx = W'($urandom_range(0, N-1));
    while (ref_bit(int'(idx)) != 1'b1) idx = idx + 8'd1;
    hashed_inp = idx;
    @(negedge clk);
    inp_vld = 1'b0;
    tests_run++;
    if (outp_vld !== 1'b1 || result !== 1'b1) begin
      failed++;
      $display("FAIL midstream_first idx=%0d: outp_vld=%b result=%b, expected 1 1",
               idx, outp_vld, result);
    end
    @(negedge clk);
    tests_run++;
    if (outp_vld !== 1'b0 || result !== 1'b1) begin
      failed++;
      $display("FAIL midstream_after: outp_vld=%b result=%b, expected 0 1", outp_vld, result);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst        = 1'b0;
    inp_vld    = 1'b0;
    hashed_inp = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_idle_gap();
    test_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
